load_store_unit: RTL and testbench

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/load_store_unit_pkg.sv | 70 +++++++
 rtl/load_store_unit_load_extend.sv | 26 ++
 rtl/load_store_unit.sv | 129 ++++++++++++
 tb/tb_load_store_unit.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/load_store_unit_pkg.sv
// Shared constants, state type and decode helpers for the load/store unit.
package load_store_unit_pkg;

    localparam logic [6:0] OPC_LOAD  = 7'b0000011;
    localparam logic [6:0] OPC_STORE = 7'b0100011;

    localparam logic [1:0] ERR_OK       = 2'b00;
    localparam logic [1:0] ERR_MISALIGN = 2'b01;
    localparam logic [1:0] ERR_ILLEGAL  = 2'b10;
    localparam logic [1:0] ERR_TIMEOUT  = 2'b11;

    localparam int unsigned FUNCT3_W = 3;

    localparam logic [FUNCT3_W-1:0] F3_BYTE   = 3'b000;
    localparam logic [FUNCT3_W-1:0] F3_HALF   = 3'b001;
    localparam logic [FUNCT3_W-1:0] F3_WORD   = 3'b010;
    localparam logic [FUNCT3_W-1:0] F3_BYTE_U = 3'b100;
    localparam logic [FUNCT3_W-1:0] F3_HALF_U = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCESS,
        ST_RESP
    } state_t;

    // Loads accept all five widths/extensions, stores only the three widths.
    function automatic logic is_legal(input logic [6:0] opcode, input logic [FUNCT3_W-1:0] funct3);
        logic ok;
        ok = 1'b0;
        if (opcode == OPC_LOAD) begin
            ok = (funct3 == F3_BYTE) || (funct3 == F3_HALF) || (funct3 == F3_WORD) ||
                 (funct3 == F3_BYTE_U) || (funct3 == F3_HALF_U);
        end else if (opcode == OPC_STORE) begin
            ok = (funct3 == F3_BYTE) || (funct3 == F3_HALF) || (funct3 == F3_WORD);
        end
        return ok;
    endfunction

    // size: 00 byte, 01 half, 10 word (funct3[1:0]).
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] offset);
        logic mis;
        case (size)
            2'b01:   mis = offset[0];
            2'b10:   mis = (offset != 2'b00);
            default: mis = 1'b0;
        endcase
        return mis;
    endfunction

    function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] offset);
        logic [3:0] m;
        case (size)
            2'b00:   m = 4'b0001 << offset;
            2'b01:   m = 4'b0011 << offset;
            default: m = 4'b1111;
        endcase
        return m;
    endfunction

    function automatic logic [31:0] replicate(input logic [1:0] size, input logic [31:0] data);
        logic [31:0] r;
        case (size)
            2'b00:   r = {4{data[7:0]}};
            2'b01:   r = {2{data[15:0]}};
            default: r = data;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/load_store_unit_load_extend.sv
// Selects the addressed lane of a read word and sign/zero-extends it.
module load_extend
    import load_store_unit_pkg::*;
(
    input  logic [FUNCT3_W-1:0] funct3,
    input  logic [1:0]          offset,
    input  logic [31:0]         word,
    output logic [31:0]         value
);

    logic [31:0] shifted;

    // Shift the addressed byte down to lane 0, then extend by load kind.
    always_comb begin
        shifted = word >> {offset, 3'b000};
        case (funct3)
            F3_BYTE:   value = {{24{shifted[7]}}, shifted[7:0]};
            F3_HALF:   value = {{16{shifted[15]}}, shifted[15:0]};
            F3_WORD:   value = shifted;
            F3_BYTE_U: value = {24'b0, shifted[7:0]};
            F3_HALF_U: value = {16'b0, shifted[15:0]};
            default:   value = '0;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding load/store unit: decodes, checks alignment, drives one
// memory request with a timeout and returns extended load data.
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [16:0] op,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        resp_valid,
    output logic [31:0] rdata,
    output logic [1:0]  err,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);

    localparam int unsigned CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    state_t              state;
    logic [CNT_W-1:0]    cnt;
    logic [CNT_W-1:0]    cnt_next;
    logic [FUNCT3_W-1:0] f3_q;
    logic [1:0]          off_q;
    logic [31:0]         ext_value;
    logic                dec_legal;
    logic                dec_mis;
    logic [1:0]          dec_size;
    logic                unused_funct7;

    // funct7 holds immediate bits for loads/stores and is never decoded.
    assign unused_funct7 = ^op[16:10];

    load_extend u_load_extend (
        .funct3 (f3_q),
        .offset (off_q),
        .word   (mem_rdata),
        .value  (ext_value)
    );

    // Decode the request currently presented by the execute stage.
    always_comb begin
        dec_size  = op[8:7];
        dec_legal = is_legal(op[6:0], op[9:7]);
        dec_mis   = is_misaligned(dec_size, addr[1:0]);
        cnt_next  = cnt + 1'b1;
    end

    // Transaction FSM with all outputs registered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            rdata      <= '0;
            err        <= ERR_OK;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_be     <= '0;
            mem_wdata  <= '0;
            cnt        <= '0;
            f3_q       <= '0;
            off_q      <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        f3_q      <= op[9:7];
                        off_q     <= addr[1:0];
                        req_ready <= 1'b0;
                        if (!dec_legal || dec_mis) begin
                            // Illegal outranks misaligned; no memory access.
                            err        <= dec_legal ? ERR_MISALIGN : ERR_ILLEGAL;
                            rdata      <= '0;
                            resp_valid <= 1'b1;
                            state      <= ST_RESP;
                        end else begin
                            mem_req   <= 1'b1;
                            mem_we    <= (op[6:0] == OPC_STORE);
                            mem_addr  <= {addr[31:2], 2'b00};
                            mem_be    <= lane_mask(dec_size, addr[1:0]);
                            mem_wdata <= replicate(dec_size, wdata);
                            cnt       <= '0;
                            state     <= ST_ACCESS;
                        end
                    end
                end
                ST_ACCESS: begin
                    if (mem_ack) begin
                        // An ack on the final permitted cycle still wins.
                        mem_req    <= 1'b0;
                        err        <= ERR_OK;
                        rdata      <= mem_we ? '0 : ext_value;
                        resp_valid <= 1'b1;
                        state      <= ST_RESP;
                    end else if (cnt_next == CNT_W'(TIMEOUT)) begin
                        mem_req    <= 1'b0;
                        err        <= ERR_TIMEOUT;
                        rdata      <= '0;
                        resp_valid <= 1'b1;
                        state      <= ST_RESP;
                    end else begin
                        cnt <= cnt_next;
                    end
                end
                ST_RESP: begin
                    resp_valid <= 1'b0;
                    req_ready  <= 1'b1;
                    state      <= ST_IDLE;
                end
                default: begin
                    state     <= ST_IDLE;
                    req_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed transactions against a
// behavioural model, plus literal expectations for the reference cases.
module tb_load_store_unit;

    localparam int unsigned TMO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [16:0] op;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        resp_valid;
    logic [31:0] rdata;
    logic [1:0]  err;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    always #5 clk = ~clk;

    load_store_unit #(.TIMEOUT(TMO)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .op         (op),
        .addr       (addr),
        .wdata      (wdata),
        .resp_valid (resp_valid),
        .rdata      (rdata),
        .err        (err),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_be     (mem_be),
        .mem_wdata  (mem_wdata),
        .mem_ack    (mem_ack),
        .mem_rdata  (mem_rdata)
    );

    typedef struct {
        logic [31:0] rdata;
        logic [1:0]  err;
    } resp_t;

    int          n_tests = 0;
    int          n_fail  = 0;
    resp_t       exp_q[$];
    logic [31:0] last_rdata;
    logic [1:0]  last_err;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic logic [16:0] mk(input logic [2:0] f3, input logic [6:0] opcode);
        return {7'b0, f3, opcode};
    endfunction

    // Reference behaviour from the architectural rules, using plain arithmetic.
    function automatic void model(input logic [16:0] o, input logic [31:0] a, input logic [31:0] wd,
                                  input logic [31:0] mrd, output bit go, output logic [3:0] be,
                                  output logic [31:0] wrep, output logic [31:0] rd, output logic [1:0] er);
        logic [6:0] opcode;
        logic [2:0] f3;
        bit         legal;
        int         size;
        int         off;
        longint     v;
        opcode = o[6:0];
        f3     = o[9:7];
        size   = 1 << f3[1:0];
        off    = int'(a % 4);
        legal  = (opcode == 7'h03 && f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}) ||
                 (opcode == 7'h23 && f3 inside {3'd0, 3'd1, 3'd2});
        be     = 4'(((1 << size) - 1) << off);
        if (size == 1)      wrep = wd[7:0] * 32'h01010101;
        else if (size == 2) wrep = wd[15:0] * 32'h00010001;
        else                wrep = wd;
        go = 1'b0;
        rd = '0;
        if (!legal) begin
            er = 2'd2;
        end else if ((off % size) != 0) begin
            er = 2'd1;
        end else begin
            go = 1'b1;
            er = 2'd0;
            if (opcode == 7'h03) begin
                v = longint'(mrd >> (8 * off)) & ((64'sd1 <<< (8 * size)) - 1);
                if (!f3[2] && size < 4 && ((v >>> (8 * size - 1)) & 1) == 1)
                    v = v - (64'sd1 <<< (8 * size));
                rd = 32'(v);
            end
        end
    endfunction

    // Scoreboard: every response pulse must match the oldest expected entry.
    always @(negedge clk) begin
        resp_t e;
        if (!rst && resp_valid) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_resp: got resp_valid=1 expected none (err=%0d)", err);
            end else begin
                e = exp_q.pop_front();
                check("resp_rdata", rdata, e.rdata);
                check("resp_err", {30'b0, err}, {30'b0, e.err});
                last_rdata = rdata;
                last_err   = err;
            end
        end
    end

    // Issue one op; ack_delay = ACCESS cycle index carrying mem_ack, -1 for never.
    task automatic run(input logic [16:0] o, input logic [31:0] a, input logic [31:0] wd,
                       input logic [31:0] mrd, input int ack_delay,
                       output logic [3:0] cap_be, output logic [31:0] cap_wdata,
                       output logic cap_we, output logic [31:0] cap_addr, output int req_cycles);
        bit          go;
        logic [3:0]  xbe;
        logic [31:0] xwrep;
        logic [31:0] xrd;
        logic [1:0]  xer;
        resp_t       e;
        int          guard;
        int          k;
        bit          done;
        model(o, a, wd, mrd, go, xbe, xwrep, xrd, xer);
        guard = 0;
        while (!req_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        if (!req_ready) check("ready_wait_timeout", {31'b0, req_ready}, 32'd1);
        if (!go)                                   begin e.rdata = xrd; e.err = xer;  end
        else if (ack_delay >= 0 && ack_delay < TMO) begin e.rdata = xrd; e.err = 2'd0; end
        else                                       begin e.rdata = '0;  e.err = 2'd3; end
        exp_q.push_back(e);
        req_valid = 1'b1;
        op        = o;
        addr      = a;
        wdata     = wd;
        @(negedge clk);
        req_valid  = 1'b0;
        req_cycles = 0;
        cap_be     = '0;
        cap_wdata  = '0;
        cap_we     = 1'b0;
        cap_addr   = '0;
        if (!go) begin
            check("err_path_no_mem_req", {31'b0, mem_req}, 32'd0);
            check("err_path_resp_valid", {31'b0, resp_valid}, 32'd1);
        end else begin
            k    = 0;
            done = 1'b0;
            while (!done) begin
                if (mem_req) req_cycles++;
                check("access_mem_req", {31'b0, mem_req}, 32'd1);
                check("access_mem_addr", mem_addr, a & 32'hFFFF_FFFC);
                check("access_mem_we", {31'b0, mem_we}, {31'b0, o[6:0] == 7'h23});
                check("access_mem_be", {28'b0, mem_be}, {28'b0, xbe});
                check("access_mem_wdata", mem_wdata, xwrep);
                if (k == 0) begin
                    cap_be    = mem_be;
                    cap_wdata = mem_wdata;
                    cap_we    = mem_we;
                    cap_addr  = mem_addr;
                    check("access_not_ready", {31'b0, req_ready}, 32'd0);
                    // A request while busy must be dropped, not queued.
                    req_valid = 1'b1;
                    addr      = 32'h0000_0F00;
                end
                if (k == ack_delay) begin
                    mem_ack   = 1'b1;
                    mem_rdata = mrd;
                end else begin
                    mem_ack   = 1'b0;
                    mem_rdata = ~mrd;
                end
                @(negedge clk);
                mem_ack   = 1'b0;
                req_valid = 1'b0;
                if (k == ack_delay || k == int'(TMO) - 1) done = 1'b1;
                k++;
            end
            check("resp_after_access", {31'b0, resp_valid}, 32'd1);
            check("mem_req_dropped", {31'b0, mem_req}, 32'd0);
        end
        @(negedge clk);
        check("resp_one_cycle", {31'b0, resp_valid}, 32'd0);
        check("ready_after_resp", {31'b0, req_ready}, 32'd1);
    endtask

    logic [3:0]  c_be;
    logic [31:0] c_wdata;
    logic        c_we;
    logic [31:0] c_addr;
    int          c_cyc;

    initial begin
        rst       = 1'b1;
        req_valid = 1'b0;
        op        = '0;
        addr      = '0;
        wdata     = '0;
        mem_ack   = 1'b0;
        mem_rdata = '0;
        repeat (3) @(negedge clk);
        check("rst_req_ready", {31'b0, req_ready}, 32'd1);
        check("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
        check("rst_rdata", rdata, 32'd0);
        check("rst_err", {30'b0, err}, 32'd0);
        check("rst_mem_req", {31'b0, mem_req}, 32'd0);
        check("rst_mem_we", {31'b0, mem_we}, 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        check("rst_mem_be", {28'b0, mem_be}, 32'd0);
        check("rst_mem_wdata", mem_wdata, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Stray ack while idle must do nothing.
        mem_ack = 1'b1;
        @(negedge clk);
        mem_ack = 1'b0;
        check("idle_ack_no_resp", {31'b0, resp_valid}, 32'd0);
        check("idle_ack_no_req", {31'b0, mem_req}, 32'd0);

        run(mk(3'b010, 7'h03), 32'h100, 32'h0, 32'hDEADBEEF, 2, c_be, c_wdata, c_we, c_addr, c_cyc);
        check("lw_lit_addr", c_addr, 32'h100);
        check("lw_lit_be", {28'b0, c_be}, 32'hF);
        check("lw_lit_rdata", last_rdata, 32'hDEADBEEF);
        check("lw_lit_err", {30'b0, last_err}, 32'd0);
        check("lw_lit_req_cycles", c_cyc, 32'd3);

        run(mk(3'b000, 7'h03), 32'h103, 32'h0, 32'h80FF1234, 0, c_be, c_wdata, c_we, c_addr, c_cyc);
        check("lb_lit_be", {28'b0, c_be}, 32'h8);
        check("lb_lit_rdata", last_rdata, 32'hFFFFFF80);

        run(mk(3'b100, 7'h03), 32'h103, 32'h0, 32'h80FF1234, 1, c_be, c_wdata, c_we, c_addr, c_cyc);
        check("lbu_lit_rdata", last_rdata, 32'h00000080);

        run(mk(3'b101, 7'h03), 32'h102, 32'h0, 32'h80FF1234, 0, c_be, c_wdata, c_we, c_addr, c_cyc);
        check("lhu_lit_rdata", last_rdata, 32'h000080FF);

        run(mk(3'b001, 7'h03), 32'h102, 32'h0, 32'h80FF1234, 0, c_be, c_wdata, c_we, c_addr, c_cyc);
        check("lh_lit_rdata", last_rdata, 32'hFFFF80FF);

        run(mk(3'b000, 7'h03), 32'h101, 32'h0, 32'h00007F00, 0, c_be, c_wdata, c_we, c_addr, c_cyc);
        check("lb_pos_lit_rdata", last_rdata, 32'h0000007F);

        run(mk(3'b001, 7'h23), 32'h202, 32'h0000ABCD, 32'h11111111, 1, c_be, c_wdata, c_we, c_addr, c_cyc);
        check("sh_lit_we", {31'b0, c_we}, 32'd1);
        check("sh_lit_be", {28'b0, c_be}, 32'hC);
        check("sh_lit_wdata", c_wdata, 32'hABCDABCD);
        check("sh_lit_rdata", last_rdata, 32'd0);
        check("sh_lit_err", {30'b0, last_err}, 32'd0);

        run(mk(3'b000, 7'h23), 32'h201, 32'h12345678, 32'h0, 0, c_be, c_wdata, c_we, c_addr, c_cyc);
        check("sb_lit_be", {28'b0, c_be}, 32'h2);
        check("sb_lit_wdata", c_wdata, 32'h78787878);

        run(mk(3'b010, 7'h23), 32'h204, 32'hCAFEF00D, 32'h0, 1, c_be, c_wdata, c_we, c_addr, c_cyc);

        run(mk(3'b010, 7'h03), 32'h101, 32'h0, 32'h0, 0, c_be, c_wdata, c_we, c_addr, c_cyc);
        check("lw_mis_lit_err", {30'b0, last_err}, 32'd1);

        run(mk(3'b001, 7'h03), 32'h103, 32'h0, 32'h0, 0, c_be, c_wdata, c_we, c_addr, c_cyc);
        run(mk(3'b011, 7'h03), 32'h100, 32'h0, 32'h0, 0, c_be, c_wdata, c_we, c_addr, c_cyc);
        check("lh011_lit_err", {30'b0, last_err}, 32'd2);

        run(mk(3'b100, 7'h23), 32'h101, 32'h0, 32'h0, 0, c_be, c_wdata, c_we, c_addr, c_cyc);
        check("illegal_priority_lit_err", {30'b0, last_err}, 32'd2);

        run(mk(3'b000, 7'h33), 32'h100, 32'h0, 32'h0, 0, c_be, c_wdata, c_we, c_addr, c_cyc);

        run(mk(3'b010, 7'h03), 32'h300, 32'h0, 32'h0, -1, c_be, c_wdata, c_we, c_addr, c_cyc);
        check("timeout_lit_req_cycles", c_cyc, 32'd4);
        check("timeout_lit_err", {30'b0, last_err}, 32'd3);
        check("timeout_lit_rdata", last_rdata, 32'd0);

        run(mk(3'b010, 7'h03), 32'h304, 32'h0, 32'h5A5A5A5A, int'(TMO) - 1, c_be, c_wdata, c_we, c_addr, c_cyc);
        check("ack_at_limit_lit_err", {30'b0, last_err}, 32'd0);
        check("ack_at_limit_lit_rdata", last_rdata, 32'h5A5A5A5A);

        // Reset in the middle of an access abandons it without a response.
        req_valid = 1'b1;
        op        = mk(3'b010, 7'h03);
        addr      = 32'h400;
        @(negedge clk);
        req_valid = 1'b0;
        check("pre_rst_mem_req", {31'b0, mem_req}, 32'd1);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("midrst_mem_req", {31'b0, mem_req}, 32'd0);
        check("midrst_req_ready", {31'b0, req_ready}, 32'd1);
        check("midrst_resp_valid", {31'b0, resp_valid}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("postrst_no_resp", {31'b0, resp_valid}, 32'd0);
        end

        run(mk(3'b010, 7'h03), 32'h500, 32'h0, 32'h01234567, 0, c_be, c_wdata, c_we, c_addr, c_cyc);
        check("post_rst_lit_rdata", last_rdata, 32'h01234567);

        check("scoreboard_drained", exp_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "global timeout");
    end

endmodule
